// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, arbiter state
// encoding and default timing parameters.
package uart_pkg;

  localparam int UART_BYTE_W        = 8;
  localparam int GRANT_W            = 3;
  localparam int TRIG_CYCLES_DEF    = 4;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after
// last_grant+1, searching upward with wrap. Reusable by other arbiters.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]       req_valid,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [N-1:0]       grant_oh,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               grant_any
);

  localparam int PW = GRANT_W + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  base;
  logic [PW-1:0]  off;
  logic [PW-1:0]  pos;

  // Rotate the request vector so bit 0 is the highest-priority requester,
  // pick the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    dbl       = {req_valid, req_valid};
    base      = {1'b0, last_grant} + PW'(1);
    rot       = '0;
    off       = '0;
    pos       = '0;
    grant_any = 1'b0;
    grant_oh  = '0;
    if (base >= PW'(N)) begin
      base = '0;
    end
    rot = N'(dbl >> base);
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_any = 1'b1;
        off       = PW'(i);
      end
    end
    pos = base + off;
    if (pos >= PW'(N)) begin
      pos = pos - PW'(N);
    end
    for (int j = 0; j < N; j++) begin
      grant_oh[j] = grant_any && (pos == PW'(j));
    end
  end

  assign grant_idx = pos[GRANT_W-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NREQ byte sources.
// Define UART_TX_ARB_TIMEOUT_EN to enable the busy-wait watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]      tx_data,
  output logic                        tx_int,
  input  logic                        tx_busy,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        active,
  output logic                        err_timeout
);

  localparam int                  TRIG_W    = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [TRIG_W-1:0]   TRIG_LOAD = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [GRANT_W-1:0]  LAST_RST  = GRANT_W'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || TRIG_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  arb_state_e               state_q;
  logic [TRIG_W-1:0]        trig_cnt_q;
  logic [UART_BYTE_W-1:0]   tx_data_q;
  logic                     tx_int_q;
  logic [NREQ-1:0]          req_ready_q;
  logic [GRANT_W-1:0]       grant_id_q;
  logic [GRANT_W-1:0]       last_grant_q;
  logic                     active_q;

  logic [NREQ-1:0]          pick_oh;
  logic [GRANT_W-1:0]       pick_idx;
  logic                     pick_any;
  logic [UART_BYTE_W-1:0]   pick_byte;

  rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_byte = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wd_q;
  logic        err_q;
  logic        wd_expired;

  assign wd_expired = (wd_q >= WD_LIMIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched byte is reset as well, so a reset mid-frame clears
      // the bus value instead of leaving a stale byte visible.
      state_q      <= IDLE;
      trig_cnt_q   <= '0;
      tx_data_q    <= '0;
      tx_int_q     <= 1'b0;
      req_ready_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RST;
      active_q     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the pre-edge register values regardless of statement order.
      req_ready_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            req_ready_q  <= pick_oh;
            tx_data_q    <= pick_byte;
            grant_id_q   <= pick_idx;
            last_grant_q <= pick_idx;
            tx_int_q     <= 1'b1;
            trig_cnt_q   <= TRIG_LOAD;
            active_q     <= 1'b1;
            state_q      <= LAUNCH;
          end
        end

        LAUNCH: begin
          if (trig_cnt_q == '0) begin
            tx_int_q <= 1'b0;
            state_q  <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_q     <= '0;
`endif
          end else begin
            trig_cnt_q <= trig_cnt_q - TRIG_W'(1);
          end
        end

        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_q    <= '0;
          end else if (wd_expired) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
`endif
          end
        end

        WAIT_DONE: begin
          if (!tx_busy) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          end else if (wd_expired) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
`endif
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_int    = tx_int_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=2, TRIG_CYCLES=4,
// TIMEOUT_CYCLES=100); inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_int;
  logic        tx_busy;
  logic [2:0]  grant_id;
  logic        active;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ           (2),
    .TRIG_CYCLES    (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_int      (tx_int),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait for an acceptance, check it, then follow tx_int through its 4-cycle
  // high phase. Returns at the falling edge after tx_int fell (WAIT_BUSY).
  task automatic expect_accept(input int id, input logic [7:0] exp_byte);
    int waited = 0;
    bit got = 1'b0;
    while (!got && waited < 50) begin
      step();
      waited++;
      if (req_ready != 2'b00) got = 1'b1;
    end
    check("accept_latency", waited, 1);
    check("req_ready_onehot", 32'(req_ready), 32'(1 << id));
    check("grant_id", 32'(grant_id), id);
    check("tx_data", 32'(tx_data), 32'(exp_byte));
    check("tx_int_rise", 32'(tx_int), 1);
    check("active_rise", 32'(active), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("tx_int_hold", 32'(tx_int), 1);
      check("ready_pulse_width", 32'(req_ready), 0);
    end
    step();
    check("tx_int_fall", 32'(tx_int), 0);
    check("tx_data_held", 32'(tx_data), 32'(exp_byte));
  endtask

  // Busy rises 3 cycles after the tx_int fall and stays high busy_len cycles.
  task automatic finish_frame(input int busy_len);
    step();
    step();
    tx_busy = 1'b1;
    repeat (busy_len) step();
    check("active_during_busy", 32'(active), 1);
    tx_busy = 1'b0;
    step();
    check("active_fall", 32'(active), 0);
    check("ready_idle", 32'(req_ready), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: observed no finish, required finish within 1ms");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit any_ready;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    tx_busy   = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_int", 32'(tx_int), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    rst_n = 1'b1;
    step();

    // Single request from requester 0.
    req_data  = 16'hB241;
    req_valid = 2'b01;
    expect_accept(0, 8'h41);
    req_valid = 2'b00;
    finish_frame(20);

    // Contention after reset: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req_data  = 16'hB1A0;
    req_valid = 2'b11;
    expect_accept(0, 8'hA0);
    finish_frame(5);
    expect_accept(1, 8'hB1);
    finish_frame(5);
    expect_accept(0, 8'hA0);
    finish_frame(5);
    expect_accept(1, 8'hB1);
    finish_frame(5);
    req_valid = 2'b00;

    // Back-pressure: requester 1 raises valid while the FSM is in WAIT_DONE.
    req_data  = 16'hB15C;
    req_valid = 2'b01;
    expect_accept(0, 8'h5C);
    req_valid = 2'b00;
    tx_busy   = 1'b1;
    step();
    req_data[15:8] = 8'h77;
    req_valid      = 2'b10;
    any_ready      = 1'b0;
    repeat (5) begin
      step();
      any_ready |= |req_ready;
    end
    check("backpressure_no_ready", 32'(any_ready), 0);
    tx_busy = 1'b0;
    step();
    check("backpressure_idle", 32'(active), 0);
    expect_accept(1, 8'h77);
    req_valid = 2'b00;
    finish_frame(4);

    // Reset mid-frame during WAIT_DONE; requester 0's byte is in flight.
    req_valid = 2'b01;
    expect_accept(0, 8'h5C);
    req_valid = 2'b00;
    tx_busy   = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_int", 32'(tx_int), 0);
    check("async_rst_active", 32'(active), 0);
    check("async_rst_tx_data", 32'(tx_data), 0);
    check("async_rst_grant_id", 32'(grant_id), 0);
    tx_busy = 1'b0;
    step();
    step();
    rst_n     = 1'b1;
    req_data  = 16'hB1A0;
    req_valid = 2'b11;
    expect_accept(0, 8'hA0);
    req_valid = 2'b00;
    finish_frame(3);

    // Busy never rises after the trigger.
    req_valid = 2'b01;
    expect_accept(0, 8'hA0);
    req_valid = 2'b00;
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 300) begin
        step();
        n++;
        if (err_timeout) seen = 1'b1;
      end
      check("timeout_delay", n, 101);
      check("timeout_active_low", 32'(active), 0);
      step();
      check("timeout_pulse_width", 32'(err_timeout), 0);
      req_valid = 2'b10;
      expect_accept(1, 8'hB1);
      req_valid = 2'b00;
      finish_frame(3);
    end
`else
    begin
      bit any_err    = 1'b0;
      bit all_active = 1'b1;
      repeat (1000) begin
        step();
        any_err    |= err_timeout;
        all_active &= active;
      end
      check("no_timeout_err", 32'(any_err), 0);
      check("no_timeout_waiting", 32'(all_active), 1);
      check("no_timeout_tx_int", 32'(tx_int), 0);
      tx_busy = 1'b1;
      step();
      tx_busy = 1'b0;
      step();
      check("late_busy_completes", 32'(active), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter between several byte sources, e.g. the RS232 echo path and the LCD/rotary combiner. It accepts one byte per requester through a valid/ready handshake and latches it. It then drives the transmitter's data/interrupt pair using the falling-edge trigger convention, and tracks the transmitter's `bps_start` busy level until the frame completes before granting again. It sits between the requesters and the UART transmitter in the top level.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `TRIG_CYCLES`, 4: cycles `tx_int` is held high before its falling edge.
- `TIMEOUT_CYCLES`, 65535: watchdog limit on waiting for busy to rise or fall (only with the macro).
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: requester i has a byte.
- `req_data` in 8*NREQ: byte for requester i in bits [8i+7:8i].
- `req_ready` out NREQ: one-hot, one-cycle acceptance pulse.
- `tx_data` out 8: byte to the transmitter.
- `tx_int` out 1: transmit trigger; the transmitter starts on its falling edge.
- `tx_busy` in 1: transmitter `bps_start` level; high while a frame is on the line.
- `grant_id` out 3: index of the requester currently served.
- `active` out 1: high from acceptance until the frame is done.
- `err_timeout` out 1: one-cycle pulse on watchdog expiry (tied 0 without the macro).

## Operation
- States: `IDLE`, `LAUNCH`, `WAIT_BUSY`, `WAIT_DONE`.
- `IDLE`:
  - If any `req_valid`, select the first set bit at or after `last_grant+1` (mod NREQ), searching upward with wrap.
  - Pulse `req_ready[sel]`, latch `req_data[sel]` into `tx_data`, set `grant_id`=sel and `last_grant`=sel.
  - Go to `LAUNCH`.
- `LAUNCH`:
  - `tx_int`=1 for exactly TRIG_CYCLES cycles, counted by a down-counter, then `tx_int`=0.
  - Go to `WAIT_BUSY` in the same cycle `tx_int` falls.
- `WAIT_BUSY`: wait for `tx_busy`=1, then go to `WAIT_DONE`.
- `WAIT_DONE`: wait for `tx_busy`=0, then go to `IDLE`.
- `tx_data` is held constant from acceptance until the next acceptance.
- `active`=1 in every state except `IDLE`.
- `req_valid` changes outside `IDLE` are ignored; no request is lost, because ready is never given.
- A requester dropping valid before acceptance is legal and is not granted.
- `tx_busy` is sampled directly; it comes from the same clock domain.

## Timing
- Reset values: `req_ready`=0, `tx_data`=8'h00, `tx_int`=0, `grant_id`=0, `active`=0, `err_timeout`=0, `last_grant`=NREQ-1 (so requester 0 wins first), state=`IDLE`.
- Acceptance latency: valid seen in `IDLE` at cycle t → `req_ready` high at t+1 (registered).
- `tx_int` rises at t+1 and falls at t+1+TRIG_CYCLES.
- Minimum spacing between two acceptances = TRIG_CYCLES + 2 + busy duration.
- `tx_busy` already high on entering `WAIT_BUSY`: advance next cycle.
- Simultaneous requests are resolved by the round-robin rule only.
- Reset asserted mid-frame: all outputs return to reset values immediately.
  - The byte in flight is dropped and its requester is not re-acked.
- With the macro, in `WAIT_BUSY` or `WAIT_DONE`, a counter exceeding TIMEOUT_CYCLES causes:
  - `err_timeout` pulse;
  - state → `IDLE`;
  - `last_grant` keeps the timed-out index.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog counter runs in `WAIT_BUSY` and `WAIT_DONE`, clearing on each state entry.
  - On expiry it forces `IDLE` and pulses `err_timeout`.
- Undefined:
  - No counter.
  - `err_timeout` is constant 0.
  - The FSM waits indefinitely on `tx_busy`.

## Structure
- Shared package `uart_pkg`: state encoding for the four states, `UART_BYTE_W`=8, the default TRIG_CYCLES, and the default TIMEOUT_CYCLES.
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req_valid` and `last_grant`.
  - Outputs: one-hot grant and encoded index.
  - Reusable by the future LCD buffer-write arbiter.

## Test plan
- Single request: `req_valid`=2'b01, `req_data[7:0]`=8'h41; busy model rises 3 cycles after the `tx_int` fall and stays high 20 cycles → `req_ready`=01 once, `tx_data`=8'h41, `tx_int` high exactly 4 cycles, `active` falls 1 cycle after busy falls.
- Contention: both valid continuously, bytes 8'hA0 and 8'hB1 → grants alternate 0,1,0,1; each `req_ready` pulse is one cycle wide.
- Back-pressure: requester 1 asserts valid while the FSM is in `WAIT_DONE` → no `req_ready` until `IDLE`, then grant 1.
- Reset mid-frame: `rst_n` low during `WAIT_DONE` → `tx_int`=0, `active`=0, `tx_data`=8'h00 asynchronously; after release requester 0 is granted first.
- Timeout (macro on, TIMEOUT_CYCLES=100): `tx_busy` held 0 → `err_timeout` pulses 101 cycles after the `tx_int` fall, then the next request is accepted normally.
- Macro off: same stimulus → FSM stays in `WAIT_BUSY` and `err_timeout` stays 0 for 1000 cycles.
